pipe_hazard_ctrl: RTL

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl_pkg.sv | 41 ++++
 rtl/pipe_hazard_ctrl_if.sv | 38 +++
 rtl/pipe_hazard_ctrl_hazard_detect.sv | 14 +
 rtl/pipe_hazard_ctrl.sv | 109 ++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline-control definitions: FSM encoding, default sizes and the
// bundled enable/flush word driven by the hazard controller.
package pipe_hazard_ctrl_pkg;

    localparam int MAX_WAIT_DEF = 15;
    localparam int CNT_W_DEF    = 16;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } hz_state_t;

    typedef struct packed {
        logic pc_we;
        logic ifid_we;
        logic idex_we;
        logic exmem_we;
        logic ifid_flush;
        logic idex_flush;
        logic memwb_flush;
    } ctrl_t;

    localparam ctrl_t CTRL_NORMAL    = ctrl_t'(7'b1111_000);
    localparam ctrl_t CTRL_LOAD_USE  = ctrl_t'(7'b0011_010);
    localparam ctrl_t CTRL_BRANCH    = ctrl_t'(7'b1111_110);
    localparam ctrl_t CTRL_MEM_STALL = ctrl_t'(7'b0000_001);
    localparam ctrl_t CTRL_FROZEN    = ctrl_t'(7'b0000_000);
    localparam ctrl_t CTRL_RESET     = ctrl_t'(7'b0000_111);

    // A taken branch squashes the younger instructions, so it wins over a load-use stall.
    function automatic ctrl_t run_rules(input logic br_taken, input logic load_use);
        if (br_taken)
            return CTRL_BRANCH;
        else if (load_use)
            return CTRL_LOAD_USE;
        else
            return CTRL_NORMAL;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle: hazard sources in, stage enables,
// bubble requests and status out.
interface pipe_hazard_ctrl_if
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);
    logic             idex_memread;
    logic [4:0]       idex_rt;
    logic [4:0]       ifid_rs;
    logic [4:0]       ifid_rt;
    logic             br_taken;
    logic             dmem_req;
    logic             dmem_ready;

    logic             pc_we;
    logic             ifid_we;
    logic             idex_we;
    logic             exmem_we;
    logic             ifid_flush;
    logic             idex_flush;
    logic             memwb_flush;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output idex_memread, idex_rt, ifid_rs, ifid_rt, br_taken, dmem_req, dmem_ready,
        input  pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_flush, memwb_flush,
        input  mem_err, stall_cnt
    );

    modport slave (
        input  idex_memread, idex_rt, ifid_rs, ifid_rt, br_taken, dmem_req, dmem_ready,
        output pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_flush, memwb_flush,
        output mem_err, stall_cnt
    );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use comparator: a load in ID/EX whose destination feeds the instruction
// in IF/ID. Register 0 is hard-wired, so it never creates a dependency.
module hazard_detect (
    input  logic       idex_memread,
    input  logic [4:0] idex_rt,
    input  logic [4:0] ifid_rs,
    input  logic [4:0] ifid_rt,
    output logic       load_use
);

    assign load_use = idex_memread && (idex_rt != 5'd0) &&
                      ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes, data-memory
// wait freezing with timeout, and a saturating stall-cycle counter.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    pipe_hazard_ctrl_if.slave bus
);

    localparam int                WAIT_W    = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    hz_state_t         state;
    hz_state_t         state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_nxt;
    logic [CNT_W-1:0]  stall_cnt;
    logic              mem_err;
    logic              mem_err_nxt;
    logic              mem_busy;
    logic              load_use;
    ctrl_t             ctrl;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    hazard_detect u_hazard_detect (
        .idex_memread (bus.idex_memread),
        .idex_rt      (bus.idex_rt),
        .ifid_rs      (bus.ifid_rs),
        .ifid_rt      (bus.ifid_rt),
        .load_use     (load_use)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_RUN;
            wait_cnt  <= '0;
            stall_cnt <= '0;
            mem_err   <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            mem_err  <= mem_err_nxt;
            if (!ctrl.pc_we)
                stall_cnt <= sat_inc(stall_cnt);
        end
    end

    // A dropped dmem_req during a wait is treated as completion, hence busy needs both.
    always_comb begin
        state_nxt   = state;
        wait_nxt    = wait_cnt;
        mem_err_nxt = mem_err;
        ctrl        = CTRL_NORMAL;
        mem_busy    = bus.dmem_req && !bus.dmem_ready;

        case (state)
            ST_RUN: begin
                if (mem_busy) begin
                    ctrl      = CTRL_MEM_STALL;
                    state_nxt = ST_MEM_WAIT;
                    wait_nxt  = '0;
                end else begin
                    ctrl = run_rules(bus.br_taken, load_use);
                end
            end
            ST_MEM_WAIT: begin
                if (mem_busy) begin
                    ctrl     = CTRL_MEM_STALL;
                    wait_nxt = wait_cnt + WAIT_W'(1);
                    if (wait_cnt == WAIT_LAST) begin
                        state_nxt   = ST_ERROR;
                        mem_err_nxt = 1'b1;
                    end
                end else begin
                    ctrl      = run_rules(bus.br_taken, load_use);
                    state_nxt = ST_RUN;
                end
            end
            ST_ERROR: begin
                ctrl = CTRL_FROZEN;
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase

        // Hold the pipeline frozen with bubbles queued for as long as reset is low.
        if (!rst)
            ctrl = CTRL_RESET;
    end

    assign bus.pc_we       = ctrl.pc_we;
    assign bus.ifid_we     = ctrl.ifid_we;
    assign bus.idex_we     = ctrl.idex_we;
    assign bus.exmem_we    = ctrl.exmem_we;
    assign bus.ifid_flush  = ctrl.ifid_flush;
    assign bus.idex_flush  = ctrl.idex_flush;
    assign bus.memwb_flush = ctrl.memwb_flush;
    assign bus.mem_err     = mem_err;
    assign bus.stall_cnt   = stall_cnt;

endmodule
